hazard_unit: RTL and testbench
==============================

Name: hazard_unit

Overview:
- Producer-side companion to the operand forwarding logic. Detects hazards that forwarding cannot resolve and drives the pipeline stall and flush controls.
- Hazards covered: load-use, results pending from the multi-cycle MUL/DIV unit (scoreboard), FENCE drain, and branch redirect.
- Sits in the decode/control area of the 5-stage core (IF, ID, EX, MEM, WB). Its outputs feed the IF/ID, ID/EX and EX/MEM pipeline register enables and clears.

Parameters:
- NREGS, 32, number of architectural registers; scoreboard width.
- MAX_PEND, 4, maximum outstanding MUL/DIV operations (range 1..15).

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- rs1_id  in  5  ID-stage source register 1
- rs2_id  in  5  ID-stage source register 2
- rd_id  in  5  ID-stage destination register
- use_rs1_id  in  1  ID instruction reads rs1
- use_rs2_id  in  1  ID instruction reads rs2
- rf_en_id  in  1  ID instruction writes rd
- mdu_op_id  in  1  ID instruction is MUL/DIV
- fence_id  in  1  ID instruction is FENCE
- rd_ex  in  5  EX-stage destination register
- mem_rd_ex  in  1  EX instruction is a load
- br_taken_ex  in  1  branch/jump redirect resolved in EX
- mdu_done  in  1  MUL/DIV result written back this cycle
- mdu_done_rd  in  5  destination of the completing MUL/DIV
- dmem_busy  in  1  data memory has not acknowledged the MEM-stage access
- stall_if  out  1  hold PC
- stall_id  out  1  hold IF/ID
- flush_id  out  1  clear IF/ID to NOP
- flush_ex  out  1  load bubble into ID/EX
- stall_mem  out  1  hold EX/MEM and MEM/WB (freeze)
- drain  out  1  FSM in DRAIN state (debug/perf)

Behaviour:
- Reset clears the scoreboard (all bits 0), pend_cnt = 0 and FSM = RUN. With idle inputs every output is 0. Reset mid-operation discards in-flight scoreboard state; a late mdu_done arriving after reset is ignored because clearing an already-0 bit is harmless.
- Outputs are combinational from inputs plus registered state, with 0-cycle latency. Scoreboard and counter update on the rising edge of clk.
- Register x0 never causes a hazard, is never set in the scoreboard, and is never a valid mdu_done_rd.
- load_use = mem_rd_ex & rd_ex!=0 & ((use_rs1_id & rs1_id==rd_ex) | (use_rs2_id & rs2_id==rd_ex)).
- sb_hit = (use_rs1_id & sb[rs1_id]) | (use_rs2_id & sb[rs2_id]) | (rf_en_id & sb[rd_id]). The rd term enforces WAW ordering.
- sb_hit is evaluated after bypassing the same-cycle mdu_done clear, so a register completing this cycle does not stall.
- mdu_full = mdu_op_id & (pend_cnt == MAX_PEND) & ~mdu_done.
- FSM:
  - RUN -> DRAIN when fence_id & (pend_cnt!=0 | dmem_busy) & ~br_taken_ex.
  - DRAIN -> RUN when pend_cnt==0 & ~dmem_busy.
  - In DRAIN the ID-stage stall is forced on. Leaving DRAIN lets the FENCE advance in the next cycle.
- Priority, highest first:
  1. dmem_busy: stall_mem=stall_if=stall_id=1, flush_ex=0, flush_id=0. Branch flush is deferred until dmem_busy drops, because the EX instruction is held.
  2. br_taken_ex: flush_id=1, flush_ex=1, stall_*=0. This overrides all ID-stage hazards because the ID instruction is squashed.
  3. id_hold = load_use | sb_hit | mdu_full | DRAIN state | (fence_id & RUN & pend/busy condition): stall_if=stall_id=1, flush_ex=1.
- Scoreboard set:
  - Condition: mdu_op_id & rf_en_id & rd_id!=0 & ~id_hold & ~stall_mem & ~br_taken_ex, i.e. the instruction actually issues.
  - Effect: set sb[rd_id] and increment pend_cnt.
- Scoreboard clear:
  - Condition: mdu_done.
  - Effect: clear sb[mdu_done_rd] and decrement pend_cnt.
- Simultaneous set and clear: pend_cnt is unchanged. If both target the same register, the set wins (the new op is younger).
- pend_cnt saturates and never wraps. An issue at MAX_PEND is impossible because of mdu_full. An mdu_done at 0 is a protocol error: assertion fires and the count stays 0.

Decomposition:
- Shared package core_pkg holds:
  - REG_W=5
  - the hz_state_e enum {HZ_RUN, HZ_DRAIN}
  - the hz_ctrl_t struct grouping stall_if, stall_id, flush_id, flush_ex and stall_mem
- Sub-module hazard_scoreboard contains the sb vector, pend_cnt, the set/clear/bypass logic and the lookup ports. The top level holds the FSM and the priority logic.

Test Plan:
- Load-use: EX load with rd_ex=5, ID has use_rs1_id=1, rs1_id=5 -> stall_if=stall_id=flush_ex=1 for exactly 1 cycle. With rd_ex=0 -> no stall.
- Scoreboard: issue MUL rd=7, then ID reads rs2=7 -> stall each cycle until mdu_done with rd=7. In the done cycle stall=0 (bypass), and pend_cnt returns 0.
- Full: issue 4 MUL/DIV (rd=1..4) with no completion, then a 5th mdu_op_id -> stall. Same cycle with mdu_done=1 -> no stall and pend_cnt stays 4.
- Fence: pend_cnt=2 and fence_id -> drain=1 with stall. After two mdu_done -> RUN next cycle, stall drops.
- Priority: br_taken_ex with load_use together -> flush_id=flush_ex=1, stall=0. Add dmem_busy=1 -> all stalls=1, flush_id=0.
- Reset: assert rst mid-DRAIN with pend_cnt=3 -> immediately all outputs 0, scoreboard clear, RUN.

Source files
------------

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared widths, hazard FSM state and pipeline control bundle
package core_pkg;
  localparam int REG_W  = 5;
  localparam int PEND_W = 4;

  typedef enum logic {
    HZ_RUN   = 1'b0,
    HZ_DRAIN = 1'b1
  } hz_state_e;

  typedef struct packed {
    logic stall_if;
    logic stall_id;
    logic flush_id;
    logic flush_ex;
    logic stall_mem;
  } hz_ctrl_t;
endpackage

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - pending MUL/DIV destination scoreboard and outstanding-op counter
module hazard_scoreboard
  import core_pkg::*;
#(
  parameter int NREGS    = 32,
  parameter int MAX_PEND = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_W-1:0]  rs1_id,
  input  logic [REG_W-1:0]  rs2_id,
  input  logic [REG_W-1:0]  rd_id,
  input  logic              use_rs1_id,
  input  logic              use_rs2_id,
  input  logic              rf_en_id,
  input  logic              mdu_op_id,
  input  logic              issue,
  input  logic              mdu_done,
  input  logic [REG_W-1:0]  mdu_done_rd,
  output logic              sb_hit,
  output logic              mdu_full,
  output logic              pend_zero,
  output logic [PEND_W-1:0] pend_cnt
);
  logic [NREGS-1:0]  sb_q, sb_d, sb_eff, set_vec, clr_vec;
  logic [PEND_W-1:0] pend_cnt_q, pend_cnt_d;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue)    set_vec[rd_id]       = 1'b1;
    if (mdu_done) clr_vec[mdu_done_rd] = 1'b1;
  end

  // Lookups see the same-cycle completion already cleared.
  assign sb_eff = sb_q & ~clr_vec;

  assign sb_hit = (use_rs1_id & sb_eff[rs1_id]) |
                  (use_rs2_id & sb_eff[rs2_id]) |
                  (rf_en_id   & sb_eff[rd_id]);

  assign pend_zero = (pend_cnt_q == '0);
  assign mdu_full  = mdu_op_id & (pend_cnt_q == PEND_W'(MAX_PEND)) & ~mdu_done;
  assign pend_cnt  = pend_cnt_q;

  always_comb begin
    sb_d    = sb_eff | set_vec;
    sb_d[0] = 1'b0;
    pend_cnt_d = pend_cnt_q;
    if (issue && !mdu_done && pend_cnt_q != PEND_W'(MAX_PEND))
      pend_cnt_d = pend_cnt_q + 1'b1;
    else if (mdu_done && !issue && pend_cnt_q != '0)
      pend_cnt_d = pend_cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_q       <= '0;
      pend_cnt_q <= '0;
    end else begin
      sb_q       <= sb_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  // A completion with nothing outstanding is a producer protocol error.
  always_ff @(posedge clk) begin
    if (!rst) assert (!(mdu_done && !issue && pend_cnt_q == '0));
  end
endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - stall/flush generation for load-use, MUL/DIV, FENCE and branch hazards
module hazard_unit
  import core_pkg::*;
#(
  parameter int NREGS    = 32,
  parameter int MAX_PEND = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] rs1_id,
  input  logic [REG_W-1:0] rs2_id,
  input  logic [REG_W-1:0] rd_id,
  input  logic             use_rs1_id,
  input  logic             use_rs2_id,
  input  logic             rf_en_id,
  input  logic             mdu_op_id,
  input  logic             fence_id,
  input  logic [REG_W-1:0] rd_ex,
  input  logic             mem_rd_ex,
  input  logic             br_taken_ex,
  input  logic             mdu_done,
  input  logic [REG_W-1:0] mdu_done_rd,
  input  logic             dmem_busy,
  output logic             stall_if,
  output logic             stall_id,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             stall_mem,
  output logic             drain
);
  hz_state_e         state_q;
  hz_ctrl_t          ctrl;
  logic              load_use, sb_hit, mdu_full, pend_zero, fence_hold, id_hold, issue;
  logic [PEND_W-1:0] pend_cnt;

  hazard_scoreboard #(.NREGS(NREGS), .MAX_PEND(MAX_PEND)) u_sb (
    .clk        (clk),
    .rst        (rst),
    .rs1_id     (rs1_id),
    .rs2_id     (rs2_id),
    .rd_id      (rd_id),
    .use_rs1_id (use_rs1_id),
    .use_rs2_id (use_rs2_id),
    .rf_en_id   (rf_en_id),
    .mdu_op_id  (mdu_op_id),
    .issue      (issue),
    .mdu_done   (mdu_done),
    .mdu_done_rd(mdu_done_rd),
    .sb_hit     (sb_hit),
    .mdu_full   (mdu_full),
    .pend_zero  (pend_zero),
    .pend_cnt   (pend_cnt)
  );

  assign load_use = mem_rd_ex & (rd_ex != '0) &
                    ((use_rs1_id & (rs1_id == rd_ex)) | (use_rs2_id & (rs2_id == rd_ex)));

  assign fence_hold = fence_id & (state_q == HZ_RUN) & (~pend_zero | dmem_busy);
  assign id_hold    = load_use | sb_hit | mdu_full | (state_q == HZ_DRAIN) | fence_hold;
  assign issue      = mdu_op_id & rf_en_id & (rd_id != '0) & ~id_hold & ~dmem_busy & ~br_taken_ex;

  // A held MEM stage also holds EX, so a resolved branch waits for the freeze to lift.
  always_comb begin
    ctrl = '0;
    if (dmem_busy) begin
      ctrl.stall_mem = 1'b1;
      ctrl.stall_if  = 1'b1;
      ctrl.stall_id  = 1'b1;
    end else if (br_taken_ex) begin
      ctrl.flush_id = 1'b1;
      ctrl.flush_ex = 1'b1;
    end else if (id_hold) begin
      ctrl.stall_if = 1'b1;
      ctrl.stall_id = 1'b1;
      ctrl.flush_ex = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HZ_RUN;
    end else begin
      case (state_q)
        HZ_RUN:   if (fence_id && (!pend_zero || dmem_busy) && !br_taken_ex) state_q <= HZ_DRAIN;
        HZ_DRAIN: if (pend_zero && !dmem_busy) state_q <= HZ_RUN;
        default:  state_q <= HZ_RUN;
      endcase
    end
  end

  assign stall_if  = ctrl.stall_if;
  assign stall_id  = ctrl.stall_id;
  assign flush_id  = ctrl.flush_id;
  assign flush_ex  = ctrl.flush_ex;
  assign stall_mem = ctrl.stall_mem;
  assign drain     = (state_q == HZ_DRAIN);
endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - directed self-checking bench for hazard_unit
module tb_hazard_unit;
  logic       clk, rst;
  logic [4:0] rs1_id, rs2_id, rd_id, rd_ex, mdu_done_rd;
  logic       use_rs1_id, use_rs2_id, rf_en_id, mdu_op_id, fence_id;
  logic       mem_rd_ex, br_taken_ex, mdu_done, dmem_busy;
  logic       stall_if, stall_id, flush_id, flush_ex, stall_mem, drain;
  int         n_checks, n_errors;

  localparam logic [5:0] O_NONE  = 6'b000000;
  localparam logic [5:0] O_HOLD  = 6'b110100;
  localparam logic [5:0] O_DRAIN = 6'b110101;
  localparam logic [5:0] O_FLUSH = 6'b001100;
  localparam logic [5:0] O_FRZ   = 6'b110010;

  hazard_unit dut (
    .clk(clk), .rst(rst),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id),
    .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id), .rf_en_id(rf_en_id),
    .mdu_op_id(mdu_op_id), .fence_id(fence_id), .rd_ex(rd_ex),
    .mem_rd_ex(mem_rd_ex), .br_taken_ex(br_taken_ex),
    .mdu_done(mdu_done), .mdu_done_rd(mdu_done_rd), .dmem_busy(dmem_busy),
    .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id),
    .flush_ex(flush_ex), .stall_mem(stall_mem), .drain(drain)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic idle();
    rs1_id = 0; rs2_id = 0; rd_id = 0; rd_ex = 0; mdu_done_rd = 0;
    use_rs1_id = 0; use_rs2_id = 0; rf_en_id = 0; mdu_op_id = 0; fence_id = 0;
    mem_rd_ex = 0; br_taken_ex = 0; mdu_done = 0; dmem_busy = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [5:0] exp);
    #1;
    chk(tag, {26'd0, stall_if, stall_id, flush_id, flush_ex, stall_mem, drain}, {26'd0, exp});
  endtask

  task automatic mdu_issue(input logic [4:0] rd);
    idle();
    mdu_op_id = 1; rf_en_id = 1; rd_id = rd;
    chk_out("issue_no_stall", O_NONE);
    tick();
  endtask

  task automatic mdu_complete(input logic [4:0] rd);
    idle();
    mdu_done = 1; mdu_done_rd = rd;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle();
    rst = 1;
    #12;
    chk_out("reset_outputs", O_NONE);
    chk("reset_pend", 32'(dut.u_sb.pend_cnt_q), 0);
    rst = 0;
    tick();

    // load-use
    mem_rd_ex = 1; rd_ex = 5; use_rs1_id = 1; rs1_id = 5;
    chk_out("load_use_rs1", O_HOLD);
    tick();
    mem_rd_ex = 0;
    chk_out("load_use_one_cycle", O_NONE);
    idle(); mem_rd_ex = 1; rd_ex = 0; use_rs1_id = 1; rs1_id = 0;
    chk_out("load_use_x0", O_NONE);
    idle(); mem_rd_ex = 1; rd_ex = 9; use_rs2_id = 1; rs2_id = 9;
    chk_out("load_use_rs2", O_HOLD);
    use_rs2_id = 0;
    chk_out("load_use_unused_src", O_NONE);

    // scoreboard RAW with completion bypass
    mdu_issue(7);
    chk("sb_pend_1", 32'(dut.u_sb.pend_cnt_q), 1);
    idle(); use_rs2_id = 1; rs2_id = 7;
    chk_out("sb_raw_stall", O_HOLD);
    tick();
    chk_out("sb_raw_stall_2", O_HOLD);
    mdu_done = 1; mdu_done_rd = 7;
    chk_out("sb_bypass", O_NONE);
    tick();
    mdu_done = 0;
    chk_out("sb_after_done", O_NONE);
    chk("sb_pend_0", 32'(dut.u_sb.pend_cnt_q), 0);

    // WAW on a pending destination
    mdu_issue(3);
    idle(); rf_en_id = 1; rd_id = 3;
    chk_out("sb_waw_stall", O_HOLD);
    mdu_complete(3);
    chk("waw_pend_0", 32'(dut.u_sb.pend_cnt_q), 0);

    // full: four outstanding, fifth stalls unless one completes this cycle
    for (int i = 1; i <= 4; i++) mdu_issue(5'(i));
    chk("full_pend_4", 32'(dut.u_sb.pend_cnt_q), 4);
    idle(); mdu_op_id = 1; rf_en_id = 1; rd_id = 10;
    chk_out("full_stall", O_HOLD);
    mdu_done = 1; mdu_done_rd = 1;
    chk_out("full_done_bypass", O_NONE);
    tick();
    chk("full_pend_stays_4", 32'(dut.u_sb.pend_cnt_q), 4);
    chk("full_sb_bits", 32'(dut.u_sb.sb_q), 32'h0000_041C);

    // fence drain with two outstanding
    mdu_complete(2);
    mdu_complete(3);
    chk("fence_pend_2", 32'(dut.u_sb.pend_cnt_q), 2);
    idle(); fence_id = 1;
    chk_out("fence_run_hold", O_HOLD);
    tick();
    chk_out("fence_drain", O_DRAIN);
    mdu_done = 1; mdu_done_rd = 4;
    chk_out("fence_drain_done1", O_DRAIN);
    tick();
    mdu_done_rd = 10;
    tick();
    mdu_done = 0;
    chk_out("fence_drain_exit_cycle", O_DRAIN);
    tick();
    chk_out("fence_run_release", O_NONE);

    // priority
    idle(); mem_rd_ex = 1; rd_ex = 5; use_rs1_id = 1; rs1_id = 5; br_taken_ex = 1;
    chk_out("prio_branch", O_FLUSH);
    dmem_busy = 1;
    chk_out("prio_dmem_busy", O_FRZ);
    idle(); dmem_busy = 1; mdu_op_id = 1; rf_en_id = 1; rd_id = 8;
    chk_out("busy_freeze", O_FRZ);
    tick();
    chk("busy_no_issue", 32'(dut.u_sb.pend_cnt_q), 0);

    // async reset mid-drain
    for (int i = 11; i <= 13; i++) mdu_issue(5'(i));
    chk("rst_pend_3", 32'(dut.u_sb.pend_cnt_q), 3);
    idle(); fence_id = 1;
    tick();
    chk_out("rst_pre_drain", O_DRAIN);
    idle();
    rst = 1;
    chk_out("rst_async_outputs", O_NONE);
    chk("rst_async_pend", 32'(dut.u_sb.pend_cnt_q), 0);
    chk("rst_async_sb", 32'(dut.u_sb.sb_q), 0);
    tick();
    rst = 0;
    use_rs1_id = 1; rs1_id = 11;
    chk_out("rst_sb_cleared", O_NONE);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
